// File: rtl/bus_arb2_nslave.sv
// bus_arb2_nslave
//   Shared single-bus interconnect. Two masters request the bus, and ownership
//   rotates round-robin, with an optional hold limit. The owner's address,
//   write strobe and write data are forwarded to NUM_SLAVES address-decoded
//   slaves. Read data is returned one cycle later through a registered
//   slave-index select, together with valid and error strobes.
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   m0_req/m1_req               bus request per master
//   m0_wr/m1_wr                 1 = write, 0 = read
//   m0_addr/m1_addr             access address
//   m0_dout/m1_dout             write data
//   m0_grant/m1_grant           registered, mutually exclusive ownership flags
//   m_din, m_rvalid, m_err      read data, read-valid strobe, unmapped-access strobe
//   s_sel, s_addr, s_wr, s_din  one-hot select and forwarded command to the slaves
//   s_dout                      slave read data; slave i at [i*DATA_W +: DATA_W]
module bus_arb2_nslave #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {16'h7000, 16'h0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {16'hFFE0, 16'hF800},
  parameter int unsigned MAX_HOLD   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m0_req,
  input  logic                         m1_req,
  input  logic                         m0_wr,
  input  logic                         m1_wr,
  input  logic [ADDR_W-1:0]            m0_addr,
  input  logic [ADDR_W-1:0]            m1_addr,
  input  logic [DATA_W-1:0]            m0_dout,
  input  logic [DATA_W-1:0]            m1_dout,
  output logic                         m0_grant,
  output logic                         m1_grant,
  output logic [DATA_W-1:0]            m_din,
  output logic                         m_rvalid,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [ADDR_W-1:0]            s_addr,
  output logic                         s_wr,
  output logic [DATA_W-1:0]            s_din,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dout
);

  localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q;       // 1: M1 was the most recent owner
  logic [HOLD_W-1:0]  hold_q;
  logic               hold_limit;

  logic               granted;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;

  logic               rd_pend_q;
  logic               err_pend_q;
  logic [IDX_W-1:0]   rd_idx_q;

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    hold_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = last_q ? G0 : G1;
        else if (m0_req)      state_d = G0;
        else if (m1_req)      state_d = G1;
      end
      G0: begin
        if (m0_req) begin
          if (hold_limit && m1_req) state_d = G1;
        end else begin
          state_d = m1_req ? G1 : IDLE;
        end
      end
      G1: begin
        if (m1_req) begin
          if (hold_limit && m0_req) state_d = G0;
        end else begin
          state_d = m0_req ? G0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == G0) last_q <= 1'b0;
      if (state_d == G1) last_q <= 1'b1;
      if (state_d != state_q) begin
        hold_q <= '0;
      end else if (state_q != IDLE && hold_q != '1) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  assign m0_grant = (state_q == G0);
  assign m1_grant = (state_q == G1);
  assign granted  = m0_grant | m1_grant;

  // ------------------------------------------------------------- forwarding
  always_comb begin
    s_addr = '0;
    s_din  = '0;
    s_wr   = 1'b0;
    if (m0_grant) begin
      s_addr = m0_addr;
      s_din  = m0_dout;
      s_wr   = m0_wr;
    end else if (m1_grant) begin
      s_addr = m1_addr;
      s_din  = m1_dout;
      s_wr   = m1_wr;
    end
  end

  // ----------------------------------------------------------------- decode
  // Ascending scan that latches the first match, so the lowest index wins on overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((s_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    s_sel = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (granted && hit && hit_idx == IDX_W'(i)) s_sel[i] = 1'b1;
    end
  end

  // ------------------------------------------------------------ read return
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      err_pend_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      rd_pend_q  <= granted & ~s_wr & hit;
      err_pend_q <= granted & ~hit;
      rd_idx_q   <= hit_idx;
    end
  end

  assign m_rvalid = rd_pend_q;
  assign m_err    = err_pend_q;

  always_comb begin
    m_din = '0;
    if (rd_pend_q) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (rd_idx_q == IDX_W'(i)) m_din = s_dout[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_bus_arb2_nslave.sv
// Directed bench for bus_arb2_nslave. The default-parameter instance covers
// decode, forwarding and read return. The second instance (MAX_HOLD=4) shares
// the inputs and is checked only for forced rotation and reset.
module tb_bus_arb2_nslave;

  logic         clk = 1'b0;
  logic         reset;
  logic         m0_req, m1_req, m0_wr, m1_wr;
  logic [15:0]  m0_addr, m1_addr;
  logic [63:0]  m0_dout, m1_dout;
  logic [127:0] s_dout;

  logic         m0_grant, m1_grant, m_rvalid, m_err, s_wr;
  logic [63:0]  m_din, s_din;
  logic [1:0]   s_sel;
  logic [15:0]  s_addr;

  logic         h_m0_grant, h_m1_grant, h_m_rvalid, h_m_err, h_s_wr;
  logic [63:0]  h_m_din, h_s_din;
  logic [1:0]   h_s_sel;
  logic [15:0]  h_s_addr;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] SLV0 = 64'h0000_0000_0000_0F0F;
  localparam logic [63:0] SLV1 = 64'h1234_5678_9ABC_DEF0;

  always #5 clk = ~clk;

  bus_arb2_nslave dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
    .m_rvalid(m_rvalid), .m_err(m_err), .s_sel(s_sel), .s_addr(s_addr),
    .s_wr(s_wr), .s_din(s_din), .s_dout(s_dout)
  );

  bus_arb2_nslave #(.MAX_HOLD(4)) dut_h (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_grant(h_m0_grant), .m1_grant(h_m1_grant), .m_din(h_m_din),
    .m_rvalid(h_m_rvalid), .m_err(h_m_err), .s_sel(h_s_sel), .s_addr(h_s_addr),
    .s_wr(h_s_wr), .s_din(h_s_din), .s_dout(s_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_wr = 0; m1_wr = 0;
    m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    s_dout = {SLV1, SLV0};
    reset = 1;
    tick();
    tick();
    vectors++;
    if ({m0_grant, m1_grant, s_sel, s_wr, m_rvalid, m_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b exp=0", {m0_grant, m1_grant, s_sel, s_wr, m_rvalid, m_err});
    end
    vectors++;
    if ({s_addr, s_din, m_din} !== '0) begin
      miscompares++;
      $display("FAIL reset_data got addr=%h din=%h mdin=%h exp=0", s_addr, s_din, m_din);
    end
    vectors++;
    if ({h_m0_grant, h_m1_grant, h_s_sel, h_m_rvalid, h_m_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_hold_inst got=%b exp=0", {h_m0_grant, h_m1_grant, h_s_sel, h_m_rvalid, h_m_err});
    end
    reset = 0;
  endtask

  task automatic test_read();
    m0_req = 1; m0_wr = 0; m0_addr = 16'h0010;
    tick();
    vectors++;
    if ({m0_grant, m1_grant, s_sel, s_wr} !== 5'b10_01_0) begin
      miscompares++;
      $display("FAIL read_addr_cycle got=%b exp=10010", {m0_grant, m1_grant, s_sel, s_wr});
    end
    vectors++;
    if (s_addr !== 16'h0010) begin
      miscompares++;
      $display("FAIL read_s_addr got=%h exp=0010", s_addr);
    end
    m0_req = 0;
    tick();
    vectors++;
    if ({m0_grant, m_rvalid, m_err} !== 3'b010 || m_din !== SLV0) begin
      miscompares++;
      $display("FAIL read_data got g=%b v=%b e=%b din=%h exp 0 1 0 %h", m0_grant, m_rvalid, m_err, m_din, SLV0);
    end
    tick();
    vectors++;
    if (m_rvalid !== 1'b0 || m_din !== 64'h0) begin
      miscompares++;
      $display("FAIL read_strobe_end got v=%b din=%h exp 0 0", m_rvalid, m_din);
    end
  endtask

  task automatic test_round_robin();
    idle_inputs();
    do_reset();
    m0_addr = 16'h0010; m1_addr = 16'h7004;
    m0_req = 1; m1_req = 1;
    tick();
    vectors++;
    if ({m0_grant, m1_grant} !== 2'b10) begin
      miscompares++;
      $display("FAIL rr_first got=%b exp=10", {m0_grant, m1_grant});
    end
    tick();
    m0_req = 0;
    tick();
    vectors++;
    if ({m0_grant, m1_grant} !== 2'b01 || m_rvalid !== 1'b1 || m_din !== SLV0) begin
      miscompares++;
      $display("FAIL rr_handover got g=%b v=%b din=%h exp 01 1 %h", {m0_grant, m1_grant}, m_rvalid, m_din, SLV0);
    end
    m1_req = 0;
    tick();
    vectors++;
    if ({m0_grant, m1_grant} !== 2'b00 || m_rvalid !== 1'b1 || m_din !== SLV1) begin
      miscompares++;
      $display("FAIL rr_release got g=%b v=%b din=%h exp 00 1 %h", {m0_grant, m1_grant}, m_rvalid, m_din, SLV1);
    end
    m0_req = 1; m1_req = 1;
    tick();
    vectors++;
    if ({m0_grant, m1_grant} !== 2'b10) begin
      miscompares++;
      $display("FAIL rr_second got=%b exp=10", {m0_grant, m1_grant});
    end
    m0_req = 0; m1_req = 0;
    tick();
  endtask

  task automatic test_write();
    m1_req = 1; m1_wr = 1; m1_addr = 16'h7004; m1_dout = 64'hFFFF;
    tick();
    vectors++;
    if ({m0_grant, m1_grant, s_sel, s_wr} !== 5'b01_10_1 || s_din !== 64'hFFFF || s_addr !== 16'h7004) begin
      miscompares++;
      $display("FAIL write_fwd got=%b din=%h addr=%h exp 01101 ffff 7004", {m0_grant, m1_grant, s_sel, s_wr}, s_din, s_addr);
    end
    m1_req = 0;
    tick();
    vectors++;
    if ({m1_grant, m_rvalid, m_err} !== 3'b000 || m_din !== 64'h0) begin
      miscompares++;
      $display("FAIL write_no_rvalid got g=%b v=%b e=%b din=%h exp 0 0 0 0", m1_grant, m_rvalid, m_err, m_din);
    end
    m1_wr = 0;
  endtask

  task automatic test_unmapped();
    m0_req = 1; m0_wr = 0; m0_addr = 16'h6060;
    tick();
    vectors++;
    if ({m0_grant, s_sel, s_wr} !== 4'b1_00_0 || s_addr !== 16'h6060) begin
      miscompares++;
      $display("FAIL unmapped_rd_sel got=%b addr=%h exp 1000 6060", {m0_grant, s_sel, s_wr}, s_addr);
    end
    m0_req = 0;
    tick();
    vectors++;
    if ({m_err, m_rvalid} !== 2'b10 || m_din !== 64'h0) begin
      miscompares++;
      $display("FAIL unmapped_rd_err got e=%b v=%b din=%h exp 1 0 0", m_err, m_rvalid, m_din);
    end
    m0_req = 1; m0_wr = 1;
    tick();
    vectors++;
    if ({m0_grant, s_sel, s_wr} !== 4'b1_00_1) begin
      miscompares++;
      $display("FAIL unmapped_wr_sel got=%b exp 1001", {m0_grant, s_sel, s_wr});
    end
    m0_req = 0; m0_wr = 0;
    tick();
    vectors++;
    if ({m_err, m_rvalid} !== 2'b10) begin
      miscompares++;
      $display("FAIL unmapped_wr_err got e=%b v=%b exp 1 0", m_err, m_rvalid);
    end
    tick();
    vectors++;
    if (m_err !== 1'b0) begin
      miscompares++;
      $display("FAIL unmapped_err_pulse got=%b exp=0", m_err);
    end
  endtask

  task automatic test_max_hold();
    logic [1:0] exp_h;
    idle_inputs();
    do_reset();
    m0_addr = 16'h0010; m1_addr = 16'h7004;
    m0_req = 1; m1_req = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_h = (((k - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
      vectors++;
      if ({h_m0_grant, h_m1_grant} !== exp_h) begin
        miscompares++;
        $display("FAIL hold4_cycle%0d got=%b exp=%b", k, {h_m0_grant, h_m1_grant}, exp_h);
      end
      vectors++;
      if ({m0_grant, m1_grant} !== 2'b10) begin
        miscompares++;
        $display("FAIL hold0_cycle%0d got=%b exp=10", k, {m0_grant, m1_grant});
      end
    end
    m0_req = 0; m1_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    do_reset();
    m1_req = 1; m1_wr = 0; m1_addr = 16'h7004;
    tick();
    vectors++;
    if ({m0_grant, m1_grant, s_sel} !== 4'b01_10) begin
      miscompares++;
      $display("FAIL rstmid_own got=%b exp=0110", {m0_grant, m1_grant, s_sel});
    end
    reset = 1;
    tick();
    vectors++;
    if ({m0_grant, m1_grant, s_sel, s_wr, m_rvalid, m_err} !== 7'b0 || {s_addr, s_din, m_din} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs got ctrl=%b addr=%h din=%h mdin=%h exp 0", {m0_grant, m1_grant, s_sel, s_wr, m_rvalid, m_err}, s_addr, s_din, m_din);
    end
    reset = 0;
    m0_req = 1; m1_req = 1; m0_addr = 16'h0010;
    tick();
    vectors++;
    if ({m0_grant, m1_grant} !== 2'b10) begin
      miscompares++;
      $display("FAIL rstmid_next_contention got=%b exp=10", {m0_grant, m1_grant});
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_unmapped();
    test_max_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
